// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared encodings for the Hi/Lo multiply/divide sequencer: operation codes,
// FSM states and small decode helpers.
package hilo_muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MSUB  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'b101);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_iter_core.sv
// One combinational iteration step: shift-add multiply (LSB first) or restoring
// division (MSB first). hi/lo hold partial product or remainder/quotient.
module hilo_muldiv_sequencer_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shift_s;
    logic [WIDTH:0] diff_s;

    // Single step; the carry of the add shifts into the top of hi.
    always_comb begin
        sum_s   = '0;
        shift_s = '0;
        diff_s  = '0;
        hi_out  = hi_in;
        lo_out  = lo_in;
        if (div_mode) begin
            shift_s = {hi_in, lo_in[WIDTH-1]};
            diff_s  = shift_s - {1'b0, opnd};
            if (diff_s[WIDTH]) begin
                hi_out = shift_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end else begin
                hi_out = diff_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            sum_s  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            hi_out = sum_s[WIDTH:1];
            lo_out = {sum_s[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative multiply/divide engine owning Hi/Lo. Works on magnitudes during RUN,
// then applies sign, accumulate and divide-by-zero rules in a single FIXUP cycle.
module hilo_muldiv_sequencer
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MoveToHi,
    input  logic             MoveToLo,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             ReadHiLo,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e                 state_r, state_nx_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             op_r;
    logic [WIDTH-1:0]       a_r, hi_pre_r, lo_pre_r, opnd_r, work_hi_r, work_lo_r;
    logic [WIDTH-1:0]       hi_r, lo_r;
    logic                   b_zero_r, sa_r, sb_r, done_r;
    logic                   accept_s, step_s, commit_s, move_hi_s, move_lo_s;
    logic                   sign_a_s, sign_b_s;
    logic [WIDTH-1:0]       mag_a_s, mag_b_s, q_s, r_s;
    logic [2*WIDTH-1:0]     prod_s, result_s;
    logic [WIDTH-1:0]       chain_hi_s [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0]       chain_lo_s [BITS_PER_CYCLE+1];

    assign sign_a_s = op_is_signed(Op) & A[WIDTH-1];
    assign sign_b_s = op_is_signed(Op) & B[WIDTH-1];
    assign mag_a_s  = sign_a_s ? -A : A;
    assign mag_b_s  = sign_b_s ? -B : B;

    assign chain_hi_s[0] = work_hi_r;
    assign chain_lo_s[0] = work_lo_r;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        hilo_muldiv_sequencer_iter_core #(.WIDTH(WIDTH)) u_core (
            .div_mode (op_is_div(op_r)),
            .hi_in    (chain_hi_s[g]),
            .lo_in    (chain_lo_s[g]),
            .opnd     (opnd_r),
            .hi_out   (chain_hi_s[g+1]),
            .lo_out   (chain_lo_s[g+1])
        );
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Next state; Flush abandons any operation in flight.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) state_nx_s = ST_RUN; else state_nx_s = ST_IDLE;
            ST_RUN:   if (Flush) state_nx_s = ST_IDLE;
                      else if (cnt_r == '0) state_nx_s = ST_FIXUP;
                      else state_nx_s = ST_RUN;
            ST_FIXUP: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Control decode: acceptance, iteration, commit and idle-time moves.
    always_comb begin
        accept_s  = 1'b0;
        step_s    = 1'b0;
        commit_s  = 1'b0;
        move_hi_s = 1'b0;
        move_lo_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s  = Start & ~Flush & op_is_legal(Op);
                move_hi_s = MoveToHi;
                move_lo_s = MoveToLo;
            end
            ST_RUN:   step_s   = ~Flush;
            ST_FIXUP: commit_s = ~Flush;
            default:  accept_s = 1'b0;
        endcase
    end

    // Sign correction and accumulate; divide-by-zero bypasses the datapath result.
    always_comb begin
        prod_s = {work_hi_r, work_lo_r};
        if (sa_r ^ sb_r) prod_s = -prod_s;
        else             prod_s = {work_hi_r, work_lo_r};
        q_s = (sa_r ^ sb_r) ? -work_lo_r : work_lo_r;
        r_s = sa_r ? -work_hi_r : work_hi_r;
        case (op_r)
            OP_MULT, OP_MULTU: result_s = prod_s;
            OP_MADD:           result_s = {hi_pre_r, lo_pre_r} + prod_s;
            OP_MSUB:           result_s = {hi_pre_r, lo_pre_r} - prod_s;
            OP_DIV, OP_DIVU:   if (b_zero_r) result_s = {a_r, {WIDTH{1'b1}}};
                               else          result_s = {r_s, q_s};
            default:           result_s = prod_s;
        endcase
    end

    // Operand latch and iteration registers; the pre-op Hi/Lo sees a same-cycle move.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r     <= '0;
            op_r      <= 3'b000;
            a_r       <= '0;
            b_zero_r  <= 1'b0;
            sa_r      <= 1'b0;
            sb_r      <= 1'b0;
            hi_pre_r  <= '0;
            lo_pre_r  <= '0;
            opnd_r    <= '0;
            work_hi_r <= '0;
            work_lo_r <= '0;
        end else if (accept_s) begin
            cnt_r     <= CNT_W'(N - 1);
            op_r      <= Op;
            a_r       <= A;
            b_zero_r  <= (B == '0);
            sa_r      <= sign_a_s;
            sb_r      <= sign_b_s;
            hi_pre_r  <= MoveToHi ? WriteData : hi_r;
            lo_pre_r  <= MoveToLo ? WriteData : lo_r;
            opnd_r    <= mag_b_s;
            work_hi_r <= '0;
            work_lo_r <= mag_a_s;
        end else if (step_s) begin
            cnt_r     <= cnt_r - CNT_W'(1);
            work_hi_r <= chain_hi_s[BITS_PER_CYCLE];
            work_lo_r <= chain_lo_s[BITS_PER_CYCLE];
        end
    end

    // Architectural Hi/Lo and the Done pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (commit_s) begin
                hi_r <= result_s[2*WIDTH-1:WIDTH];
                lo_r <= result_s[WIDTH-1:0];
            end else begin
                if (move_hi_s) hi_r <= WriteData;
                if (move_lo_s) lo_r <= WriteData;
            end
        end
    end

    assign Hi    = hi_r;
    assign Lo    = lo_r;
    assign Done  = done_r;
    assign Busy  = (state_r != ST_IDLE);
    assign Stall = Busy & (Start | ReadHiLo | MoveToHi | MoveToLo);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Scoreboard bench for hilo_muldiv_sequencer: one DUT per BITS_PER_CYCLE (1 and 2)
// sharing stimulus; the selected DUT is checked against an arithmetic reference model.
module tb_hilo_muldiv_sequencer;

    localparam logic [2:0] K_MULT  = 3'd0;
    localparam logic [2:0] K_MULTU = 3'd1;
    localparam logic [2:0] K_DIV   = 3'd2;
    localparam logic [2:0] K_DIVU  = 3'd3;
    localparam logic [2:0] K_MADD  = 3'd4;
    localparam logic [2:0] K_MSUB  = 3'd5;

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;

    logic        clk, reset, start, move_hi, move_lo, read_hilo, flush;
    logic [2:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi1, lo1, hi2, lo2, hi_s, lo_s;
    logic        busy1, done1, stall1, busy2, done2, stall2;
    logic        busy_s, done_s, stall_s, sel;
    int          cyc, last_done, n_sel, checks, errors;
    logic [31:0] m_hi, m_lo;
    exp_t        sb_q[$];
    exp_t        mon_e;

    hilo_muldiv_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
        .MoveToHi(move_hi), .MoveToLo(move_lo), .WriteData(wdata), .ReadHiLo(read_hilo),
        .Flush(flush), .Hi(hi1), .Lo(lo1), .Busy(busy1), .Done(done1), .Stall(stall1));

    hilo_muldiv_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
        .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
        .MoveToHi(move_hi), .MoveToLo(move_lo), .WriteData(wdata), .ReadHiLo(read_hilo),
        .Flush(flush), .Hi(hi2), .Lo(lo2), .Busy(busy2), .Done(done2), .Stall(stall2));

    assign hi_s    = sel ? hi2 : hi1;
    assign lo_s    = sel ? lo2 : lo1;
    assign busy_s  = sel ? busy2 : busy1;
    assign done_s  = sel ? done2 : done1;
    assign stall_s = sel ? stall2 : stall1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (bpc=%0d cycle %0d)", name, act, exp, sel ? 2 : 1, cyc);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] h, input logic [31:0] l);
        int     sx, sy;
        longint sp;
        sx = x;
        sy = y;
        sp = longint'(sx) * longint'(sy);
        case (o)
            K_MULT:  return sp;
            K_MULTU: return {32'h0, x} * {32'h0, y};
            K_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            K_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            K_MADD:  return {h, l} + sp;
            K_MSUB:  return {h, l} - sp;
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h80000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h0;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every Done must match the oldest expected result and its due cycle.
    always @(negedge clk) begin
        if (reset && done_s) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=Done expected=no Done (bpc=%0d cycle %0d)", sel ? 2 : 1, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("hilo", {hi_s, lo_s}, mon_e.val);
                chk("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic tick_check();
        logic eb;
        eb = (cyc < last_done);
        chk("busy", 64'(busy_s), 64'(eb));
        chk("stall", 64'(stall_s), 64'(eb & (start | read_hilo | move_hi | move_lo)));
    endtask

    task automatic wait_idle_drive();
        int  g;
        logic ok;
        ok = 1'b0;
        for (g = 0; g < 300; g++) begin
            #1;
            tick_check();
            if (cyc >= last_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=still busy expected=idle (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic use_fixed, input logic [63:0] fixed, input logic track,
                         output int sc);
        logic [63:0] e;
        exp_t        t;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        wait_idle_drive();
        sc = cyc;
        if (track) begin
            e = use_fixed ? fixed : ref_model(o, x, y, m_hi, m_lo);
            t.val = e;
            t.due = cyc + n_sel + 2;
            sb_q.push_back(t);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        last_done = cyc + n_sel + 2;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic move(input logic he, input logic le, input logic [31:0] d);
        @(negedge clk);
        move_hi = he; move_lo = le; wdata = d;
        wait_idle_drive();
        if (he) m_hi = d;
        if (le) m_lo = d;
        @(posedge clk);
        #1 begin move_hi = 1'b0; move_lo = 1'b0; end
    endtask

    task automatic drain_check();
        for (int g = 0; g < 300 && cyc < last_done; g++) @(negedge clk);
        #1;
        chk("drain_busy", 64'(busy_s), 64'(0));
        chk("hi", 64'(hi_s), 64'(m_hi));
        chk("lo", 64'(lo_s), 64'(m_lo));
        chk("pending", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b1; read_hilo = 1'b1; op = K_MULT;
        #1 chk("reset_stall", 64'(stall_s), 64'(0));
        repeat (2) @(negedge clk);
        chk("reset_hilo", {hi_s, lo_s}, 64'(0));
        chk("reset_busy", 64'(busy_s), 64'(0));
        chk("reset_done", 64'(done_s), 64'(0));
        start = 1'b0; read_hilo = 1'b0; reset = 1'b1;
        sb_q.delete();
        m_hi = 32'h0; m_lo = 32'h0; last_done = 0;
    endtask

    task automatic run_phase();
        int sc;
        do_reset();
        issue(K_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA, 1'b1, sc);
        issue(K_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 1'b1, sc);
        issue(K_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1, sc);
        issue(K_DIV, 32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFFFFFF}, 1'b1, sc);
        issue(K_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 1'b1, sc);
        move(1'b1, 1'b0, 32'd1);
        move(1'b0, 1'b1, 32'hFFFFFFFF);
        issue(K_MADD, 32'd1, 32'd1, 1'b1, {32'd2, 32'd0}, 1'b1, sc);
        move(1'b1, 1'b1, 32'd0);
        issue(K_MSUB, 32'd1, 32'd1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, sc);
        drain_check();

        // Busy without a request does not stall; ReadHiLo and a held Start do.
        issue(K_MULT, pick(), pick(), 1'b0, 64'h0, 1'b1, sc);
        repeat (3) begin @(negedge clk); #1 tick_check(); end
        read_hilo = 1'b1;
        repeat (3) begin @(negedge clk); #1 tick_check(); end
        issue(K_MULTU, pick(), pick(), 1'b0, 64'h0, 1'b1, sc);
        read_hilo = 1'b0;
        drain_check();

        // Illegal op, and Start together with Flush, are both ignored in IDLE.
        @(negedge clk);
        start = 1'b1; op = 3'b110; #1 tick_check();
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1 tick_check();
        start = 1'b1; flush = 1'b1; op = K_MULT;
        @(posedge clk); #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk); #1 tick_check();

        // Flush at +10 leaves Hi/Lo untouched and produces no Done.
        move(1'b1, 1'b1, 32'h55);
        issue(K_MULT, 32'd3, 32'd3, 1'b0, 64'h0, 1'b0, sc);
        while (cyc < sc + 10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        last_done = cyc;
        @(negedge clk); #1 tick_check();
        chk("flush_hilo", {hi_s, lo_s}, {32'h55, 32'h55});
        repeat (40) @(negedge clk);
        drain_check();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) move(1'b1, 1'($urandom_range(0, 1)), pick());
            else issue(3'($urandom_range(0, 5)), pick(), pick(), 1'b0, 64'h0, 1'b1, sc);
        end
        drain_check();

        // Asynchronous reset mid-divide clears everything immediately.
        issue(K_DIV, 32'hDEADBEEF, 32'd7, 1'b0, 64'h0, 1'b0, sc);
        repeat (5) @(negedge clk);
        read_hilo = 1'b1;
        reset = 1'b0;
        #1;
        chk("areset_hilo", {hi_s, lo_s}, 64'(0));
        chk("areset_busy", 64'(busy_s), 64'(0));
        chk("areset_done", 64'(done_s), 64'(0));
        chk("areset_stall", 64'(stall_s), 64'(0));
        @(negedge clk);
        reset = 1'b1; read_hilo = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0; last_done = 0;
        repeat (40) @(negedge clk);
        drain_check();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_done = 0;
        reset = 1'b0; start = 1'b0; move_hi = 1'b0; move_lo = 1'b0; read_hilo = 1'b0;
        flush = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0; wdata = 32'h0;
        m_hi = 32'h0; m_lo = 32'h0;
        sel = 1'b0; n_sel = 32;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_phase();
        sel = 1'b1; n_sel = 16;
        run_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
